// File: rtl/cla_seq_adder_pkg.sv
// rtl/cla_seq_adder_pkg.sv - shared state encodings and default widths for the sequential CLA adder
package cla_seq_adder_pkg;

  localparam int DEF_N = 32;
  localparam int DEF_M = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/cla_slice_mb.sv
// rtl/cla_slice_mb.sv - combinational M-bit carry-lookahead slice
module cla_slice_mb #(
  parameter int M = 8
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         c_in,
  output logic [M-1:0] s,
  output logic         c_out,
  output logic         c_msb
);

  logic [M-1:0] g;
  logic [M-1:0] p;
  logic [M:0]   c;
  logic         grp_g;
  logic         grp_p;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is formed from the group generate/propagate of bits i..0 and c_in,
  // so no carry depends on another computed carry.
  always_comb begin
    c     = '0;
    grp_g = 1'b0;
    grp_p = 1'b0;
    c[0]  = c_in;
    for (int i = 0; i < M; i++) begin
      grp_g = g[i];
      grp_p = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        grp_g = grp_g | (grp_p & g[j]);
        grp_p = grp_p & p[j];
      end
      c[i+1] = grp_g | (grp_p & c_in);
    end
  end

  assign s     = p ^ c[M-1:0];
  assign c_out = c[M];
  assign c_msb = c[M-1];

endmodule

// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle N-bit add/subtract reusing one M-bit CLA slice
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ofl,
  output logic         zero
);

  localparam int NCHUNK = N / M;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    opa_q, opa_d;
  logic [N-1:0]    opb_q, opb_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            c_out_q, c_out_d;
  logic            ofl_q, ofl_d;
  logic            zero_q, zero_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic [M-1:0]    sl_a, sl_b, sl_s;
  logic            sl_cout, sl_cmsb;

  assign sl_a = opa_q[idx_q*M +: M];
  assign sl_b = opb_q[idx_q*M +: M];

  cla_slice_mb #(.M(M)) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .c_in  (carry_q),
    .s     (sl_s),
    .c_out (sl_cout),
    .c_msb (sl_cmsb)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ofl_d   = ofl_q;
    zero_d  = zero_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Subtract is A + ~B + 1, so the inversion and forced carry happen at accept.
          state_d = ST_RUN;
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub | c_in;
          idx_d   = '0;
          sum_d   = '0;
          c_out_d = 1'b0;
          ofl_d   = 1'b0;
          zero_d  = 1'b0;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*M +: M] = sl_s;
        carry_d             = sl_cout;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          idx_d   = '0;
          c_out_d = sl_cout;
          ofl_d   = sl_cmsb ^ sl_cout;
          zero_d  = (sum_d == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ofl_q   <= 1'b0;
      zero_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ofl_q   <= ofl_d;
      zero_q  <= zero_d;
      idx_q   <= idx_d;
    end
  end

  assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ofl   = ofl_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - randomized self-checking bench for cla_seq_adder at M=8, M=4 and M=16
module tb_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst, start, sub, c_in;
  logic [31:0] a, b;

  logic        rdy8, dn8, co8, of8, z8;
  logic [31:0] sum8;
  logic        rdy4, dn4, co4, of4, z4;
  logic [31:0] sum4;
  logic        rdy16, dn16, co16, of16, z16;
  logic [31:0] sum16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.N(32), .M(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
    .ready(rdy8), .done(dn8), .sum(sum8), .c_out(co8), .ofl(of8), .zero(z8)
  );
  cla_seq_adder #(.N(32), .M(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
    .ready(rdy4), .done(dn4), .sum(sum4), .c_out(co4), .ofl(of4), .zero(z4)
  );
  cla_seq_adder #(.N(32), .M(16)) u16 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
    .ready(rdy16), .done(dn16), .sum(sum16), .c_out(co16), .ofl(of16), .zero(z16)
  );

  // Reference: plain integer arithmetic, signed overflow from the true signed result range.
  task automatic model(input logic [31:0] ma, mb, input logic msub, mcin,
                       output logic [31:0] s, output logic co, of, z);
    logic [32:0] full;
    longint      sa, sb, r;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      s  = ma - mb;
      co = (ma >= mb);
      r  = sa - sb;
    end else begin
      full = {1'b0, ma} + {1'b0, mb} + {32'd0, mcin};
      s    = full[31:0];
      co   = full[32];
      r    = sa + sb + longint'(mcin);
    end
    of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    z  = (s == 32'd0);
  endtask

  // Presents one operation, then advances until the M=8 unit signals done; lat=0 means timeout.
  task automatic run_op(input logic [31:0] ia, ib, input logic isub, icin, output int lat);
    a = ia; b = ib; sub = isub; c_in = icin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int e = 1; e <= 20; e++) begin
      if (dn8) begin
        lat = e;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; a = 32'h1234_5678; b = 32'h1; sub = 1'b0; c_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    total++;
    if (rdy8 !== 1'b1 || dn8 !== 1'b0 || sum8 !== 32'd0 || co8 !== 1'b0 || of8 !== 1'b0 || z8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b done=%b sum=%h c=%b o=%b z=%b required 1 0 00000000 0 0 0",
               rdy8, dn8, sum8, co8, of8, z8);
    end
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      total++;
      if (dn8 !== 1'b0 || rdy8 !== 1'b1) begin
        bad++;
        $display("FAIL reset_start_dropped: edge %0d done=%b ready=%b required 0 1", e, dn8, rdy8);
      end
    end
  endtask

  task automatic test_directed;
    logic [31:0] ta[6] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'h00FF_FFFF, 32'd0};
    logic [31:0] tb[6] = '{32'd1, 32'd1, 32'd1, 32'd7, 32'd1, 32'd0};
    logic        ts[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        tc[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] te[6] = '{32'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h0100_0001, 32'd0};
    logic [31:0] es;
    logic        ec, eo, ez;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      model(ta[i], tb[i], ts[i], tc[i], es, ec, eo, ez);
      run_op(ta[i], tb[i], ts[i], tc[i], lat);
      total++;
      if (lat != 5) begin
        bad++;
        $display("FAIL directed_latency[%0d]: got %0d edges required 5", i, lat);
      end
      total++;
      if (sum8 !== te[i] || sum8 !== es) begin
        bad++;
        $display("FAIL directed_sum[%0d]: got %h required %h", i, sum8, te[i]);
      end
      total++;
      if (co8 !== ec || of8 !== eo || z8 !== ez) begin
        bad++;
        $display("FAIL directed_flags[%0d]: c/o/z got %b%b%b required %b%b%b", i, co8, of8, z8, ec, eo, ez);
      end
      @(posedge clk); #1;
      total++;
      if (dn8 !== 1'b0) begin
        bad++;
        $display("FAIL directed_done_pulse[%0d]: done=%b required 0", i, dn8);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] ra, rb, es;
    logic        rs, rc, ec, eo, ez;
    int          lat;
    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 6 == 0) rb = ra;
      rs = 1'($urandom_range(1)); rc = 1'($urandom_range(1));
      model(ra, rb, rs, rc, es, ec, eo, ez);
      run_op(ra, rb, rs, rc, lat);
      total++;
      if (lat != 5 || sum8 !== es || co8 !== ec || of8 !== eo || z8 !== ez) begin
        bad++;
        $display("FAIL random[%0d]: a=%h b=%h sub=%b cin=%b lat=%0d sum=%h c/o/z=%b%b%b required lat=5 sum=%h c/o/z=%b%b%b",
                 i, ra, rb, rs, rc, lat, sum8, co8, of8, z8, es, ec, eo, ez);
      end
    end
  endtask

  task automatic test_busy_start;
    logic [31:0] es;
    logic        ec, eo, ez;
    int          lat, extra;
    model(32'h1357_9BDF, 32'h0246_8ACE, 1'b0, 1'b0, es, ec, eo, ez);
    a = 32'h1357_9BDF; b = 32'h0246_8ACE; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 32'hDEAD_BEEF; b = 32'hFFFF_0000; sub = 1'b1; c_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'h0; b = 32'h0;
    lat = 0;
    for (int e = 3; e <= 20; e++) begin
      if (dn8) begin
        lat = e;
        break;
      end
      @(posedge clk); #1;
    end
    total++;
    if (lat != 5 || sum8 !== es || co8 !== ec || of8 !== eo || z8 !== ez) begin
      bad++;
      $display("FAIL busy_start_ignored: lat=%0d sum=%h c/o/z=%b%b%b required lat=5 sum=%h c/o/z=%b%b%b",
               lat, sum8, co8, of8, z8, es, ec, eo, ez);
    end
    extra = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (dn8) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL busy_single_done: extra done cycles=%0d required 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(32'd10, 32'd20, 1'b0, 1'b0, lat);
    total++;
    if (lat != 5 || sum8 !== 32'd30) begin
      bad++;
      $display("FAIL b2b_first: lat=%0d sum=%h required 5 0000001e", lat, sum8);
    end
    run_op(32'd3, 32'd4, 1'b0, 1'b0, lat);
    total++;
    if (lat != 5 || sum8 !== 32'd7 || co8 !== 1'b0 || z8 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second: lat=%0d sum=%h c=%b z=%b required 5 00000007 0 0", lat, sum8, co8, z8);
    end
    a = 32'd1; b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (dn8 !== 1'b0 || sum8 !== 32'd0 || rdy8 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_clear: done=%b sum=%h ready=%b required 0 00000000 0", dn8, sum8, rdy8);
    end
    repeat (6) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid;
    int extra;
    a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (rdy8 !== 1'b1 || dn8 !== 1'b0 || sum8 !== 32'd0 || co8 !== 1'b0 || of8 !== 1'b0 || z8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_state: rdy=%b done=%b sum=%h c/o/z=%b%b%b required 1 0 00000000 000",
               rdy8, dn8, sum8, co8, of8, z8);
    end
    extra = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (dn8 || rdy8 !== 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL reset_mid_no_done: bad cycles=%0d required 0", extra);
    end
  endtask

  task automatic test_param_sweep;
    logic [31:0] ra, rb, es;
    logic        rs, rc, ec, eo, ez;
    logic [31:0] s4, s16;
    logic        c4, o4, zz4, c16, o16, zz16;
    int          l4, l8, l16, waited;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        ra = 32'h00FF_FFFF; rb = 32'd1; rs = 1'b0; rc = 1'b1;
      end else begin
        ra = $urandom; rb = $urandom;
        rs = 1'($urandom_range(1)); rc = 1'($urandom_range(1));
      end
      waited = 0;
      while (!(rdy4 && rdy8 && rdy16) && waited < 40) begin
        @(posedge clk); #1;
        waited++;
      end
      total++;
      if (waited >= 40) begin
        bad++;
        $display("FAIL sweep_idle_wait[%0d]: ready4/8/16=%b%b%b required 111", i, rdy4, rdy8, rdy16);
      end
      model(ra, rb, rs, rc, es, ec, eo, ez);
      a = ra; b = rb; sub = rs; c_in = rc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      l4 = 0; l8 = 0; l16 = 0;
      s4 = '0; s16 = '0; c4 = 0; o4 = 0; zz4 = 0; c16 = 0; o16 = 0; zz16 = 0;
      for (int e = 1; e <= 20; e++) begin
        if (dn4 && l4 == 0) begin
          l4 = e; s4 = sum4; c4 = co4; o4 = of4; zz4 = z4;
        end
        if (dn8 && l8 == 0) l8 = e;
        if (dn16 && l16 == 0) begin
          l16 = e; s16 = sum16; c16 = co16; o16 = of16; zz16 = z16;
        end
        if (l4 != 0 && l8 != 0 && l16 != 0) break;
        @(posedge clk); #1;
      end
      total++;
      if (l4 != 9 || l8 != 5 || l16 != 3) begin
        bad++;
        $display("FAIL sweep_latency[%0d]: m4=%0d m8=%0d m16=%0d required 9 5 3", i, l4, l8, l16);
      end
      total++;
      if (s4 !== es || c4 !== ec || o4 !== eo || zz4 !== ez) begin
        bad++;
        $display("FAIL sweep_m4[%0d]: sum=%h c/o/z=%b%b%b required %h %b%b%b", i, s4, c4, o4, zz4, es, ec, eo, ez);
      end
      total++;
      if (s16 !== es || c16 !== ec || o16 !== eo || zz16 !== ez) begin
        bad++;
        $display("FAIL sweep_m16[%0d]: sum=%h c/o/z=%b%b%b required %h %b%b%b", i, s16, c16, o16, zz16, es, ec, eo, ez);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; c_in = 1'b0; a = '0; b = '0;
    test_reset;
    test_directed;
    test_random;
    test_busy_start;
    test_back_to_back;
    test_reset_mid;
    test_param_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Parametrised multi-cycle N-bit add/subtract unit.
- Reuses one M-bit carry-lookahead slice over N/M cycles, least-significant chunk first, with a registered carry between cycles.
- Adds subtract mode and signed-overflow, carry and zero flags, behind a start/ready/done handshake.
- Sits beside the ALU for wide or area-constrained arithmetic where the latency is acceptable.

Parameters:
- N, 32: operand/result width; must be a multiple of M.
- M, 8: slice width in bits; power of two, at least 4.
- NCHUNK, N/M: derived localparam; number of RUN cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; accepted only when ready=1.
- sub  input  1  1 = A-B (A+~B+1), 0 = A+B+c_in; sampled with start.
- a  input  N  operand A; sampled with start.
- b  input  N  operand B; sampled with start.
- c_in  input  1  carry-in for add; ignored when sub=1.
- ready  output  1  high in IDLE and DONE.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  N  result; held until the next accepted start.
- c_out  output  1  carry out of bit N-1; for sub, 1 = no borrow (A>=B unsigned).
- ofl  output  1  signed overflow = carry into bit N-1 XOR carry out of bit N-1.
- zero  output  1  sum==0.

Behaviour:
- Reset and clock: the only clock is clk; rst is synchronous and active-high.
- Reset values: state=IDLE; ready=1; done=0; sum=0; c_out=0; ofl=0; zero=0; internal operand, carry and chunk-index registers=0.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> RUN while idx<NCHUNK-1.
  - RUN -> DONE when idx==NCHUNK-1.
  - DONE -> RUN on start; DONE -> IDLE otherwise after its one cycle.
- Accept edge (start=1 and ready=1):
  - Latch opA=a.
  - Latch opB = sub ? ~b : b.
  - Latch carry = sub ? 1 : c_in.
  - Clear idx to 0.
  - Clear sum and all flags to 0.
- Each RUN edge:
  - Slice computes opA[idx*M +: M] + opB[idx*M +: M] + carry.
  - Write sum[idx*M +: M].
  - Load carry with the slice carry-out.
  - Increment idx.
  - On the last chunk, also register c_out, ofl (from the slice carry into its MSB XOR slice carry-out) and zero (full next-sum==0).
- Latency: done=1 in the cycle after the NCHUNK-th RUN edge, i.e. NCHUNK+1 edges after the accept edge. For N=32, M=8 that is 5. done is never high for more than one cycle per operation.
- start while busy: start in RUN is ignored with no side effects; a, b, sub and c_in may change freely during RUN.
- Back-to-back: start in the DONE cycle is accepted. Next state is RUN, done falls, and the prior result is cleared on that edge.
- Reset mid-operation: rst overrides everything. The next state is IDLE with reset values, and no done is produced for the aborted operation.
- rst and start in the same cycle: rst wins; start is dropped.
- Flags and sum are valid from the done cycle until the next accept edge.

Decomposition:
- Shared include file:
  - 2-bit state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
  - Default N/M constants, so the ALU and benches agree.
- Sub-module cla_slice_mb (parameter M):
  - Purely combinational M-bit carry-lookahead slice built from group propagate/generate.
  - Inputs: a, b, c_in.
  - Outputs: s, c_out, c_msb (carry into bit M-1).
  - The top level holds the FSM, operand/carry/index registers and flag logic.

Test Plan:
1. N=32, M=8; a=32'hFFFF_FFFF, b=1, sub=0, c_in=0 -> done 5 edges after accept; sum=0, c_out=1, zero=1, ofl=0.
2. a=32'h7FFF_FFFF, b=1, sub=0 -> sum=32'h8000_0000, ofl=1, c_out=0, zero=0.
3. a=32'h8000_0000, b=1, sub=1 -> sum=32'h7FFF_FFFF, ofl=1, c_out=1; then a=5, b=7, sub=1 -> sum=32'hFFFF_FFFE, c_out=0, ofl=0.
4. Handshake:
   - start pulsed mid-RUN with different operands -> ignored; original result reported, single done pulse.
   - start held high in the DONE cycle with a=3, b=4 -> accepted; next done 5 edges later with sum=7.
5. Reset mid-operation: rst at the 2nd RUN edge -> next cycle ready=1, done=0, sum=0, all flags 0; no done pulse follows.
6. Carry chain and parameter sweep:
   - a=32'h00FF_FFFF, b=1, c_in=1 -> sum=32'h0100_0001 (carry crosses three chunk boundaries).
   - Repeat a random compare against a reference model with M=4 and M=16 (done at 9 and 3 edges).
